// File: rtl/memory_io_if.sv
// Request/response bus between the MIPS datapath and memory_io.
// The master issues req/we/addr/wdata/be; the slave answers with ready and a registered rdata/rvalid.
interface memory_io_if;
  logic        req;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, we, addr, wdata, be, input ready, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata, rvalid);
endinterface

// File: rtl/memory_io.sv
// Word RAM plus memory-mapped inports, input-update status word and outport for the MIPS datapath.
// Define MEM_BYTE_LANES_EN to honour byte enables (RAM partial writes go through a read-modify-write state).
module memory_io #(
  parameter int          RAM_DEPTH    = 256,
  parameter int          NUM_INPORTS  = 2,
  parameter logic [31:0] IO_BASE      = 32'h0000_FFF0,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_FFEC,
  parameter logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  memory_io_if.slave  bus,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_sel,
  input  logic        in_en,
  input  logic        in_clr,
  output logic [31:0] outport
);
  localparam int          AW        = $clog2(RAM_DEPTH);
  localparam logic [29:0] OUT_W     = OUTPORT_ADDR[31:2];
  localparam logic [29:0] IO_W      = IO_BASE[31:2];
  localparam logic [29:0] IO_LAST_W = IO_BASE[31:2] + 30'(NUM_INPORTS - 1);
  localparam logic [29:0] STAT_W    = STATUS_ADDR[31:2];

  logic [31:0]   mem [RAM_DEPTH];
  logic [31:0]   ram_rd_q;
  logic          ram_we;
  logic [AW-1:0] ram_widx;
  logic [31:0]   ram_wdata;

  logic [29:0]   word;
  logic [AW-1:0] ram_idx;
  logic [29:0]   port_off;
  logic          sel_out, sel_in, sel_stat, sel_ram;
  logic          accept, rd_acc, wr_acc;
  logic [3:0]    wr_be;
  logic          unused_addr_lo;

  logic [31:0]            inport_q [NUM_INPORTS];
  logic [31:0]            inport_d [NUM_INPORTS];
  logic [NUM_INPORTS-1:0] status_q, status_d;
  logic [31:0]            outport_q, outport_d;
  logic                   load_ok;

  logic        rvalid_q, rvalid_d;
  logic        rd_ram_q, rd_ram_d;
  logic [31:0] rd_io_q, rd_io_d;
  logic [31:0] io_rd;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign word           = bus.addr[31:2];
  assign ram_idx        = bus.addr[AW+1:2];
  assign port_off       = word - IO_W;
  assign unused_addr_lo = ^bus.addr[1:0];
  assign accept         = bus.req & bus.ready;
  assign rd_acc         = accept & ~bus.we;
  assign wr_acc         = accept & bus.we;

`ifdef MEM_BYTE_LANES_EN
  assign wr_be = bus.be;
`else
  logic unused_be;
  assign wr_be     = 4'hF;
  assign unused_be = ^bus.be;
`endif

  always_comb begin
    sel_out  = 1'b0;
    sel_in   = 1'b0;
    sel_stat = 1'b0;
    sel_ram  = 1'b0;
    if (word == OUT_W)                         sel_out  = 1'b1;
    else if (word >= IO_W && word <= IO_LAST_W) sel_in   = 1'b1;
    else if (word == STAT_W)                   sel_stat = 1'b1;
    else if (word < STAT_W)                    sel_ram  = 1'b1;
  end

  // Inports and status flags: load sets the flag after a same-cycle status read has cleared it; in_clr overrides both.
  assign load_ok = in_en & (int'(in_sel) < NUM_INPORTS);

  always_comb begin
    status_d = status_q;
    if (rd_acc && sel_stat) status_d = '0;
    for (int i = 0; i < NUM_INPORTS; i++) begin
      inport_d[i] = inport_q[i];
      if (load_ok && int'(in_sel) == i) begin
        inport_d[i] = in_data;
        status_d[i] = 1'b1;
      end
    end
    if (in_clr) begin
      status_d = '0;
      for (int i = 0; i < NUM_INPORTS; i++) inport_d[i] = '0;
    end
    outport_d = outport_q;
    if (wr_acc && sel_out) outport_d = merge_be(outport_q, bus.wdata, wr_be);
  end

  for (genvar gi = 0; gi < NUM_INPORTS; gi++) begin : g_inport
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) inport_q[gi] <= '0;
      else      inport_q[gi] <= inport_d[gi];
    end
  end

  always_comb begin
    io_rd = '0;
    if (sel_out) begin
      io_rd = outport_q;
    end else if (sel_in) begin
      for (int i = 0; i < NUM_INPORTS; i++) begin
        if (port_off == 30'(i)) io_rd = inport_q[i];
      end
    end else if (sel_stat) begin
      io_rd = 32'(status_q);
    end
  end

  // rdata comes either from the RAM output register or the I/O register; the source flag holds between reads.
  always_comb begin
    rvalid_d = rd_acc;
    rd_ram_d = rd_ram_q;
    rd_io_d  = rd_io_q;
    if (rd_acc) begin
      rd_ram_d = sel_ram;
      if (!sel_ram) rd_io_d = io_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q  <= '0;
      outport_q <= '0;
      rvalid_q  <= 1'b0;
      rd_ram_q  <= 1'b0;
      rd_io_q   <= '0;
    end else begin
      status_q  <= status_d;
      outport_q <= outport_d;
      rvalid_q  <= rvalid_d;
      rd_ram_q  <= rd_ram_d;
      rd_io_q   <= rd_io_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rd_ram_q ? ram_rd_q : rd_io_q;
  assign outport    = outport_q;

`ifdef MEM_BYTE_LANES_EN
  typedef enum logic {S_IDLE, S_RMW} state_t;

  state_t        state_q;
  logic          ready_q;
  logic [AW-1:0] rmw_idx_q;
  logic [31:0]   rmw_wdata_q;
  logic [3:0]    rmw_be_q;
  logic [31:0]   rmw_old_q;
  logic          rmw_start;

  assign rmw_start = wr_acc & sel_ram & (wr_be != 4'hF) & (wr_be != 4'h0);

  // Reset while in RMW returns to IDLE before the merge edge, so the target word keeps its old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rmw_idx_q   <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rmw_start) begin
            state_q     <= S_RMW;
            ready_q     <= 1'b0;
            rmw_idx_q   <= ram_idx;
            rmw_wdata_q <= bus.wdata;
            rmw_be_q    <= wr_be;
          end
        end
        S_RMW: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign ram_we    = (wr_acc & sel_ram & (wr_be == 4'hF)) | (state_q == S_RMW);
  assign ram_widx  = (state_q == S_RMW) ? rmw_idx_q : ram_idx;
  assign ram_wdata = (state_q == S_RMW) ? merge_be(rmw_old_q, rmw_wdata_q, rmw_be_q) : bus.wdata;
`else
  assign bus.ready = 1'b1;
  assign ram_we    = wr_acc & sel_ram;
  assign ram_widx  = ram_idx;
  assign ram_wdata = bus.wdata;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_widx] <= ram_wdata;
    if (rd_acc && sel_ram) ram_rd_q <= mem[ram_idx];
`ifdef MEM_BYTE_LANES_EN
    if (rmw_start) rmw_old_q <= mem[ram_idx];
`endif
  end
endmodule

// File: tb/tb_memory_io.sv
// Scoreboard bench for memory_io: a driver updates a behavioural model and queues expected read data,
// a negedge monitor compares every rvalid, the held rdata, ready and outport against it.
module tb_memory_io;
  localparam int          RAM_DEPTH = 256;
  localparam int          NIN       = 2;
  localparam logic [31:0] IO_BASE   = 32'h0000_FFF0;
  localparam logic [31:0] STAT      = 32'h0000_FFEC;
  localparam logic [31:0] OUTA      = 32'h0000_FFFC;
`ifdef MEM_BYTE_LANES_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_en = 1'b0;
  logic        in_clr = 1'b0;
  logic [31:0] outport;

  memory_io_if bus();

  memory_io #(
    .RAM_DEPTH(RAM_DEPTH), .NUM_INPORTS(NIN), .IO_BASE(IO_BASE),
    .STATUS_ADDR(STAT), .OUTPORT_ADDR(OUTA)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .in_data(in_data), .in_sel(in_sel),
    .in_en(in_en), .in_clr(in_clr), .outport(outport)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [RAM_DEPTH];
  logic [31:0] m_out = '0;
  logic [31:0] m_in [3] = '{default: '0};
  logic [2:0]  m_stat = '0;
  bit          rmw_pending = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // 0 = RAM, 1 = outport, 2 = inport, 3 = status, 4 = unmapped
  function automatic int kind(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (w == OUTA) return 1;
    if (w >= IO_BASE && w < IO_BASE + 32'(4 * NIN)) return 2;
    if (w == STAT) return 3;
    if (w < STAT) return 0;
    return 4;
  endfunction

  task automatic model_edge(input bit acc, input bit w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] b, input bit ie, input logic [1:0] is,
                            input logic [31:0] id, input bit ic);
    int k, idx, pidx;
    bit pend;
    k    = kind(a);
    idx  = int'(a[31:2]) % RAM_DEPTH;
    pidx = int'(((a & ~32'd3) - IO_BASE) >> 2);
    pend = 1'b0;
    if (acc && !w) begin
      case (k)
        0:       exp_q.push_back(m_ram[idx]);
        1:       exp_q.push_back(m_out);
        2:       exp_q.push_back(m_in[pidx]);
        3:       exp_q.push_back({29'd0, m_stat});
        default: exp_q.push_back(32'd0);
      endcase
      if (k == 3) m_stat = '0;
    end
    if (acc && w) begin
      if (k == 0) begin
        if (!BL || b == 4'hF) m_ram[idx] = wd;
        else if (b != 4'h0) begin
          m_ram[idx] = merge(m_ram[idx], wd, b);
          pend = 1'b1;
        end
      end else if (k == 1) begin
        m_out = BL ? merge(m_out, wd, b) : wd;
      end
    end
    rmw_pending = pend;
    if (ic) begin
      m_in   = '{default: '0};
      m_stat = '0;
    end else if (ie && int'(is) < NIN) begin
      m_in[is]   = id;
      m_stat[is] = 1'b1;
    end
  endtask

  // Called at a negedge; drives one cycle and returns at the following negedge.
  task automatic cyc(input bit rq, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input bit ie = 1'b0, input logic [1:0] is = 2'd0,
                     input logic [31:0] id = 32'd0, input bit ic = 1'b0);
    bit acc;
    bus.req = rq; bus.we = w; bus.addr = a; bus.wdata = wd; bus.be = b;
    in_en = ie; in_sel = is; in_data = id; in_clr = ic;
    acc = rq && !rmw_pending;
    if (acc) $display("txn %s addr=%h wdata=%h be=%h", w ? "WR" : "RD", a, wd, b);
    @(posedge clk);
    model_edge(acc, w, a, wd, b, ie, is, id, ic);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("ready", 32'(bus.ready), 32'(!rmw_pending));
      if (bus.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid: got rvalid=1, expected no pending read");
        end else begin
          last_rd = exp_q.pop_front();
          chk("rdata", bus.rdata, last_rd);
        end
      end else begin
        chk("rdata_hold", bus.rdata, last_rd);
      end
      chk("outport", outport, m_out);
    end
  end

  initial begin
    logic [31:0] a, saved;
    logic [3:0]  b;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_outport", outport, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < RAM_DEPTH; i++) cyc(1, 1, 32'(4 * i), $urandom, 4'hF);

    cyc(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    cyc(1, 0, 32'h10, 32'h0, 4'hF);
    cyc(1, 0, 32'h410, 32'h0, 4'hF);
    cyc(0, 0, 32'h0, 32'h0, 4'h0, 1'b1, 2'd1, 32'h55);
    cyc(1, 0, IO_BASE + 32'd4, 32'h0, 4'hF);
    cyc(1, 0, STAT, 32'h0, 4'hF);
    cyc(1, 0, STAT, 32'h0, 4'hF);
    cyc(1, 0, STAT, 32'h0, 4'hF, 1'b1, 2'd0, 32'h77);
    cyc(1, 0, STAT, 32'h0, 4'hF);
    cyc(1, 1, 32'h20, 32'h1122_3344, 4'hF);
    cyc(1, 1, 32'h20, 32'h0000_AA00, 4'b0010);
    cyc(1, 0, 32'h20, 32'h0, 4'hF);
    cyc(1, 0, 32'h20, 32'h0, 4'hF);
    cyc(1, 1, OUTA, 32'h0000_1234, 4'hF);
    chk("outport_1234", outport, 32'h0000_1234);
    cyc(1, 0, 32'h0000_FFF8, 32'h0, 4'hF);
    cyc(0, 0, 32'h0, 32'h0, 4'h0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50)      a = 32'($urandom_range(0, 32'h0000_FFEB));
      else if (r < 60) a = OUTA;
      else if (r < 75) a = IO_BASE + 32'(4 * $urandom_range(0, 2));
      else if (r < 85) a = STAT;
      else             a = $urandom | 32'h0001_0000;
      a[1:0] = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 99) < 40) ? 4'hF : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom, b,
          $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 19) == 0);
    end
    cyc(0, 0, 32'h0, 32'h0, 4'h0);

    // Reset while a partial write sits in RMW.
    cyc(1, 1, OUTA, 32'hFFFF_FFFF, 4'hF);
    cyc(1, 1, 32'h40, 32'hCAFE_F00D, 4'hF);
    saved = m_ram[16];
    cyc(1, 1, 32'h40, 32'h0000_0077, 4'b0001);
    bus.req = 1'b0;
    #2 rst = 1'b0;
    if (BL) m_ram[16] = saved;
    rmw_pending = 1'b0;
    m_out   = '0;
    m_in    = '{default: '0};
    m_stat  = '0;
    last_rd = '0;
    exp_q.delete();
    @(negedge clk);
    chk("rmw_rst_ready", 32'(bus.ready), 32'd1);
    chk("rmw_rst_outport", outport, 32'd0);
    chk("rmw_rst_rvalid", 32'(bus.rvalid), 32'd0);
    rst = 1'b1;
    cyc(1, 0, 32'h40, 32'h0, 4'hF);
    cyc(1, 0, STAT, 32'h0, 4'hF);
    cyc(0, 0, 32'h0, 32'h0, 4'h0);
    cyc(0, 0, 32'h0, 32'h0, 4'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_io.md
# memory_io

Parametrised instruction/data memory with memory-mapped I/O for the MIPS datapath. A valid/ready request port replaces the bare MemRead/MemWrite strobes. Adds a configurable RAM depth, 1–3 input ports, sticky input-update status flags and optional byte-lane writes via read-modify-write. Sits between the datapath's memory-address/write-data registers and the memory-data register.

## Interface
- RAM_DEPTH, 256: RAM words; power of two, 16..4096.
- NUM_INPORTS, 2: input port count, 1..3.
- IO_BASE, 32'h0000_FFF0: address of inport 0; inport i at IO_BASE+4*i.
- STATUS_ADDR, 32'h0000_FFEC: input-update status word (read only).
- OUTPORT_ADDR, 32'h0000_FFFC: output port (read/write).

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  request valid
- ready  out  1  request accepted when req & ready at a rising edge
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  write data
- be  in  4  byte enables, be[0] = bits 7:0
- rdata  out  32  read data
- rvalid  out  1  rdata valid, one-cycle pulse
- in_data  in  32  shared input-port data bus
- in_sel  in  2  input port select
- in_en  in  1  load in_data into inport in_sel
- in_clr  in  1  synchronous clear of all inports and status flags
- outport  out  32  output port register

## Operation
- Decode priority: OUTPORT_ADDR, then inport window (IO_BASE..IO_BASE+4*(NUM_INPORTS-1)), then STATUS_ADDR, then RAM. Any other address at or above STATUS_ADDR is unmapped.
- RAM index is addr[log2(RAM_DEPTH)+1:2]. Addresses below STATUS_ADDR wrap modulo RAM_DEPTH words.
- Read of RAM, inport, outport or status returns that value. Unmapped read returns 0, with rvalid still asserted.
- Status word: bit i is set when inport i is loaded. Bits above NUM_INPORTS-1 read 0.
  - An accepted status read clears all bits.
  - A load in the same cycle as a status read: the read returns the pre-load flags and the loaded port's bit ends set (set wins).
- in_en with in_sel >= NUM_INPORTS is ignored.
- in_clr beats a same-cycle in_en.
- Writes to inport, status or unmapped addresses are dropped silently; no rvalid.
- Writes to outport merge by be in a single cycle.
- FSM states: IDLE and RMW (RMW exists only with MEM_BYTE_LANES_EN).
  - IDLE: ready=1.
  - Partial RAM write (be != 4'hF and be != 0) → RMW.
  - RMW: ready=0. Merges the read word with wdata per be, writes RAM, → IDLE.
  - be = 4'h0 write: no-op, stays IDLE.
- Reset values: ready=1, rvalid=0, rdata=0, outport=0, all inports=0, status=0, FSM=IDLE. RAM contents are not reset.

## Timing
- Read accepted at edge T: rdata/rvalid valid during T→T+1. rdata holds its value after rvalid drops.
- Reads may be issued back to back, one per cycle.
- Full-word write accepted at T: RAM or outport updated at T. A read of the same address accepted at T+1 returns the new data.
- Partial write accepted at T: ready=0 during T→T+1, RAM updated at edge T+1, ready=1 from T+1.
- Input port loaded at the edge where in_en=1. Visible to a read accepted at the following edge.
- Reset asserted mid-RMW: the merge is abandoned, RAM is left at its old value, FSM=IDLE.

## Configuration
- MEM_BYTE_LANES_EN defined: be honoured on RAM (via RMW) and on outport.
- MEM_BYTE_LANES_EN undefined:
  - be is ignored and every write is a full word, single cycle.
  - The RMW state is absent and ready is tied to 1 after reset.
  - Status, inports and decode are unchanged.

## Test plan
- Reset, write 0xDEADBEEF to 0x10, read 0x10 → rvalid one cycle later with rdata=0xDEADBEEF. Read 0x410 (RAM_DEPTH=256) → 0xDEADBEEF (wrap).
- in_sel=1, in_en=1, in_data=0x55. Read IO_BASE+4 → 0x55. Read STATUS_ADDR → 0x2, then → 0x0.
- in_en for port 0 in the same cycle as a status read → read returns 0x0; next status read → 0x1.
- Macro on: word 0x11223344 at 0x20, write be=4'b0010 with wdata=0x0000AA00 → ready low one cycle; read → 0x1122AA44. Macro off: same write → 0x0000AA00.
- Write 0x1234 to OUTPORT_ADDR → outport=0x1234 next cycle. Unmapped read 0xFFF8 with NUM_INPORTS=2 → rdata=0.
- Assert rst during RMW → ready=1, outport=0, target RAM word unchanged.
